// File: rtl/uart_cmd_parser_if.sv
// Command-parser bus: received byte strobe in, held command with ready/valid
// handshake out, plus error reporting. Clock and reset stay plain ports.
interface uart_cmd_parser_if;
  logic        i_Rx_DV;
  logic [7:0]  i_Rx_Byte;
  logic        o_Cmd_Valid;
  logic        i_Cmd_Ready;
  logic [2:0]  o_Cmd_Joint;
  logic [15:0] o_Cmd_Pos;
  logic        o_Err_Pulse;
  logic [1:0]  o_Err_Code;
  logic [7:0]  o_Err_Count;

  // Parser side: consumes bytes and ready, produces command and errors.
  modport slave (
    input  i_Rx_DV,
    input  i_Rx_Byte,
    input  i_Cmd_Ready,
    output o_Cmd_Valid,
    output o_Cmd_Joint,
    output o_Cmd_Pos,
    output o_Err_Pulse,
    output o_Err_Code,
    output o_Err_Count
  );

  // Host side: supplies bytes and ready, observes command and errors.
  modport master (
    output i_Rx_DV,
    output i_Rx_Byte,
    output i_Cmd_Ready,
    input  o_Cmd_Valid,
    input  o_Cmd_Joint,
    input  o_Cmd_Pos,
    input  o_Err_Pulse,
    input  o_Err_Code,
    input  o_Err_Count
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// UART command parser: frames of SYNC(0xAA), ID, POS_H, POS_L, CHK with
// CHK = ID ^ POS_H ^ POS_L. A good frame is handed to the consumer through a
// one-deep valid/ready holding register; bad ID, bad checksum, inter-byte
// timeout and dropped frames are reported as single-cycle error pulses.
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CLKS = 26040,
  parameter int unsigned NUM_JOINTS   = 6
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  uart_cmd_parser_if.slave bus
);

  localparam logic [7:0]  SYNC_BYTE   = 8'hAA;
  localparam logic [7:0]  JOINT_LIMIT = 8'(NUM_JOINTS);
  // The counter "reaches" TIMEOUT_CLKS-1 on the edge where it would step
  // there from TIMEOUT_CLKS-2; the timeout is taken on that edge instead.
  localparam logic [15:0] IDLE_LAST   = 16'(TIMEOUT_CLKS - 2);

  localparam logic [1:0] ERR_CHK     = 2'd0;
  localparam logic [1:0] ERR_ID      = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_DROP    = 2'd3;

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_ID   = 3'd1,
    S_POSH = 3'd2,
    S_POSL = 3'd3,
    S_CHK  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [15:0] r_idle_cnt;
  logic [15:0] w_idle_cnt_next;

  logic [7:0]  r_id;
  logic [7:0]  r_pos_h;
  logic [7:0]  r_pos_l;

  logic        r_cmd_valid;
  logic [2:0]  r_cmd_joint;
  logic [15:0] r_cmd_pos;

  logic        r_err_pulse;
  logic [1:0]  r_err_code;
  logic [7:0]  r_err_count;

  logic [7:0]  w_chk_calc;
  logic        w_id_bad;
  logic        w_chk_ok;
  logic        w_timeout;
  logic        w_cap_id;
  logic        w_cap_posh;
  logic        w_cap_posl;
  logic        w_frame_done;
  logic        w_fsm_err;
  logic [1:0]  w_fsm_err_code;
  logic        w_load;
  logic        w_drop;
  logic        w_err;
  logic [1:0]  w_err_code;

  // Expected checksum, one XOR lane per bit of the captured fields.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_chk
      assign w_chk_calc[gi] = r_id[gi] ^ r_pos_h[gi] ^ r_pos_l[gi];
    end
  endgenerate

  // Full-byte ID compare so out-of-range upper bits are rejected too.
  assign w_id_bad  = (bus.i_Rx_Byte >= JOINT_LIMIT);
  assign w_chk_ok  = (bus.i_Rx_Byte == w_chk_calc);
  // A byte on the expiry edge wins over the timeout.
  assign w_timeout = (r_state != S_SYNC) && !bus.i_Rx_DV && (r_idle_cnt == IDLE_LAST);

  // FSM state register.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state <= S_SYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state, field-capture strobes and frame-level errors.
  always_comb begin
    w_state_next   = r_state;
    w_cap_id       = 1'b0;
    w_cap_posh     = 1'b0;
    w_cap_posl     = 1'b0;
    w_frame_done   = 1'b0;
    w_fsm_err      = 1'b0;
    w_fsm_err_code = ERR_CHK;
    if (w_timeout) begin
      w_state_next   = S_SYNC;
      w_fsm_err      = 1'b1;
      w_fsm_err_code = ERR_TIMEOUT;
    end else if (bus.i_Rx_DV) begin
      case (r_state)
        S_SYNC: begin
          // Anything but SYNC is line noise between frames: drop silently.
          if (bus.i_Rx_Byte == SYNC_BYTE) begin
            w_state_next = S_ID;
          end
        end
        S_ID: begin
          if (w_id_bad) begin
            w_state_next   = S_SYNC;
            w_fsm_err      = 1'b1;
            w_fsm_err_code = ERR_ID;
          end else begin
            w_cap_id     = 1'b1;
            w_state_next = S_POSH;
          end
        end
        S_POSH: begin
          w_cap_posh   = 1'b1;
          w_state_next = S_POSL;
        end
        S_POSL: begin
          w_cap_posl   = 1'b1;
          w_state_next = S_CHK;
        end
        S_CHK: begin
          w_state_next = S_SYNC;
          if (w_chk_ok) begin
            w_frame_done = 1'b1;
          end else begin
            w_fsm_err      = 1'b1;
            w_fsm_err_code = ERR_CHK;
          end
        end
        default: begin
          w_state_next = S_SYNC;
        end
      endcase
    end
  end

  // Hand-off decision and merged error source; a drop needs a byte strobe
  // and a timeout needs its absence, so only one error can fire per cycle.
  always_comb begin
    w_load     = w_frame_done && (!r_cmd_valid || bus.i_Cmd_Ready);
    w_drop     = w_frame_done && r_cmd_valid && !bus.i_Cmd_Ready;
    w_err      = w_fsm_err || w_drop;
    w_err_code = w_drop ? ERR_DROP : w_fsm_err_code;
  end

  // Idle counter next value: cleared by bytes and by a timeout, runs mid-frame.
  always_comb begin
    w_idle_cnt_next = r_idle_cnt;
    if (bus.i_Rx_DV || w_timeout) begin
      w_idle_cnt_next = 16'd0;
    end else if (r_state != S_SYNC) begin
      w_idle_cnt_next = r_idle_cnt + 16'd1;
    end
  end

  // Idle counter register.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_idle_cnt <= 16'd0;
    end else begin
      r_idle_cnt <= w_idle_cnt_next;
    end
  end

  // Capture frame fields as they arrive.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_id    <= 8'd0;
      r_pos_h <= 8'd0;
      r_pos_l <= 8'd0;
    end else begin
      if (w_cap_id) begin
        r_id <= bus.i_Rx_Byte;
      end
      if (w_cap_posh) begin
        r_pos_h <= bus.i_Rx_Byte;
      end
      if (w_cap_posl) begin
        r_pos_l <= bus.i_Rx_Byte;
      end
    end
  end

  // One-deep command holding register with valid/ready handshake.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_cmd_valid <= 1'b0;
      r_cmd_joint <= 3'd0;
      r_cmd_pos   <= 16'd0;
    end else if (w_load) begin
      r_cmd_valid <= 1'b1;
      r_cmd_joint <= r_id[2:0];
      r_cmd_pos   <= {r_pos_h, r_pos_l};
    end else if (bus.i_Cmd_Ready) begin
      r_cmd_valid <= 1'b0;
    end
  end

  // Error strobe, latest cause and saturating total.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_err_pulse <= 1'b0;
      r_err_code  <= ERR_CHK;
      r_err_count <= 8'd0;
    end else begin
      r_err_pulse <= w_err;
      if (w_err) begin
        r_err_code <= w_err_code;
        if (r_err_count != 8'hFF) begin
          r_err_count <= r_err_count + 8'd1;
        end
      end
    end
  end

  assign bus.o_Cmd_Valid = r_cmd_valid;
  assign bus.o_Cmd_Joint = r_cmd_joint;
  assign bus.o_Cmd_Pos   = r_cmd_pos;
  assign bus.o_Err_Pulse = r_err_pulse;
  assign bus.o_Err_Code  = r_err_code;
  assign bus.o_Err_Count = r_err_count;

endmodule
